// File: rtl/fetch_stage_pkg.sv
// Shared types and default constants for the WISC-SP20 instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned DATA_W_DEF    = 16;
    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: instruction, PC+2, valid and error flag.
// Flush wins over load; with neither asserted every field holds.
module fetch_stage_if_id #(
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [DATA_W-1:0] d_instr,
    input  logic [DATA_W-1:0] d_pc_plus2,
    input  logic              d_valid,
    input  logic              d_err,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] pc_plus2,
    output logic              valid,
    output logic              err
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_INSTR;
            pc_plus2 <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else if (flush) begin
            instr    <= NOP_INSTR;
            pc_plus2 <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else if (load) begin
            instr    <= d_instr;
            pc_plus2 <= d_pc_plus2;
            valid    <= d_valid;
            err      <= d_err;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, multi-cycle imem handshake, hazard hold buffer, redirect/halt.
//   state   | meaning
//   FETCH   | request at pc (idle for one cycle right after reset)
//   WAIT    | request outstanding, memory not done yet
//   HOLD    | word captured while decode stalls; request dropped
//   DRAIN   | finishing an abandoned access at the old address, data discarded
//   HALTED  | no fetching; left only by redirect or reset
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [DATA_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [DATA_W-1:0] redirect_pc_i,
    input  logic              halt_i,
    output logic [DATA_W-1:0] imem_addr_o,
    output logic              imem_rd_o,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              imem_done_i,
    input  logic              imem_stall_i,
    input  logic              imem_err_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [DATA_W-1:0] pc_plus2_o,
    output logic              valid_o,
    output logic              err_o
);

    fetch_state_t      state_q, state_n;
    logic [DATA_W-1:0] pc_q, pc_n, addr_q, addr_n, hbuf_q, hbuf_n, pc_inc;
    logic              rd_q, rd_n, hbuf_err_q, hbuf_err_n, halt_pend_q, halt_pend_n;
    logic              done, outstanding, mem_busy;
    logic              lat_load, lat_flush, lat_valid, lat_err;
    logic [DATA_W-1:0] lat_instr, lat_pc2;

    // imem_stall_i is implied by rd && !done; kept only as an observable port.
    assign mem_busy    = imem_stall_i;
    assign done        = imem_done_i & rd_q;
    assign outstanding = rd_q & ~imem_done_i;
    assign pc_inc      = pc_q + DATA_W'(2);

    always_comb begin
        state_n     = state_q;
        pc_n        = pc_q;
        hbuf_n      = hbuf_q;
        hbuf_err_n  = hbuf_err_q;
        halt_pend_n = halt_pend_q;
        lat_load    = 1'b0;
        lat_flush   = 1'b0;
        lat_instr   = NOP_INSTR;
        lat_pc2     = '0;
        lat_valid   = 1'b0;
        lat_err     = 1'b0;
        if (redirect_i) begin
            pc_n        = redirect_pc_i;
            halt_pend_n = redirect_pc_i[0] & outstanding;
            if (redirect_pc_i[0]) begin
                lat_load  = 1'b1;
                lat_valid = 1'b1;
                lat_err   = 1'b1;
            end else if (state_q != ST_DRAIN) begin
                lat_flush = 1'b1;
            end
            if (outstanding)           state_n = ST_DRAIN;
            else if (redirect_pc_i[0]) state_n = ST_HALTED;
            else                       state_n = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH, ST_WAIT: begin
                    if (halt_i) begin
                        lat_flush = ~stall_i;
                        if (outstanding) begin
                            state_n     = ST_DRAIN;
                            halt_pend_n = 1'b1;
                        end else begin
                            state_n = ST_HALTED;
                        end
                    end else if (!done) begin
                        // no new word: decode gets a bubble unless it is stalled
                        lat_flush = ~stall_i;
                        state_n   = rd_q ? ST_WAIT : ST_FETCH;
                    end else if (!stall_i) begin
                        lat_load  = 1'b1;
                        lat_instr = imem_rdata_i;
                        lat_pc2   = pc_inc;
                        lat_valid = 1'b1;
                        lat_err   = imem_err_i;
                        pc_n      = pc_inc;
                        state_n   = imem_err_i ? ST_HALTED : ST_FETCH;
                    end else begin
                        hbuf_n     = imem_rdata_i;
                        hbuf_err_n = imem_err_i;
                        pc_n       = pc_inc;
                        state_n    = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (halt_i) begin
                        lat_flush = ~stall_i;
                        state_n   = ST_HALTED;
                    end else if (!stall_i) begin
                        // pc already advanced past the buffered word, so it is that word's PC+2
                        lat_load  = 1'b1;
                        lat_instr = hbuf_q;
                        lat_pc2   = pc_q;
                        lat_valid = 1'b1;
                        lat_err   = hbuf_err_q;
                        state_n   = hbuf_err_q ? ST_HALTED : ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    lat_flush = ~stall_i;
                    if (done) begin
                        state_n     = (halt_pend_q | halt_i) ? ST_HALTED : ST_FETCH;
                        halt_pend_n = 1'b0;
                    end else if (halt_i) begin
                        halt_pend_n = 1'b1;
                    end
                end
                ST_HALTED: lat_flush = ~stall_i;
                default:   state_n = ST_FETCH;
            endcase
        end
        rd_n   = (state_n == ST_FETCH) || (state_n == ST_WAIT) || (state_n == ST_DRAIN);
        addr_n = (state_n == ST_DRAIN) ? addr_q : pc_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            rd_q        <= 1'b0;
            hbuf_q      <= '0;
            hbuf_err_q  <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            pc_q        <= pc_n;
            addr_q      <= addr_n;
            rd_q        <= rd_n;
            hbuf_q      <= hbuf_n;
            hbuf_err_q  <= hbuf_err_n;
            halt_pend_q <= halt_pend_n & ~mem_busy | halt_pend_n;
        end
    end

    assign imem_addr_o = addr_q;
    assign imem_rd_o   = rd_q;

    fetch_stage_if_id #(
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (lat_load),
        .flush      (lat_flush),
        .d_instr    (lat_instr),
        .d_pc_plus2 (lat_pc2),
        .d_valid    (lat_valid),
        .d_err      (lat_err),
        .instr      (instr_o),
        .pc_plus2   (pc_plus2_o),
        .valid      (valid_o),
        .err        (err_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: drives the imem handshake by hand and checks hand-computed results.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0, redirect_i = 1'b0, halt_i = 1'b0;
    logic [15:0] redirect_pc_i = '0;
    logic [15:0] imem_addr_o;
    logic        imem_rd_o;
    logic [15:0] imem_rdata_i = '0;
    logic        imem_done_i = 1'b0, imem_stall_i = 1'b0, imem_err_i = 1'b0;
    logic [15:0] instr_o, pc_plus2_o;
    logic        valid_o, err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .imem_addr_o   (imem_addr_o),
        .imem_rd_o     (imem_rd_o),
        .imem_rdata_i  (imem_rdata_i),
        .imem_done_i   (imem_done_i),
        .imem_stall_i  (imem_stall_i),
        .imem_err_i    (imem_err_i),
        .instr_o       (instr_o),
        .pc_plus2_o    (pc_plus2_o),
        .valid_o       (valid_o),
        .err_o         (err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
        imem_stall_i = imem_rd_o & ~imem_done_i;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        total++; if (imem_rd_o !== 1'b0)      begin bad++; $display("FAIL rst_rd got=%b exp=0", imem_rd_o); end
        total++; if (imem_addr_o !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h exp=0000", imem_addr_o); end
        total++; if (instr_o !== 16'h0800)     begin bad++; $display("FAIL rst_instr got=%h exp=0800", instr_o); end
        total++; if (pc_plus2_o !== 16'h0000)  begin bad++; $display("FAIL rst_pc2 got=%h exp=0000", pc_plus2_o); end
        total++; if (valid_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", valid_o, err_o); end
        rst_n = 1'b1;
        step();
        total++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0000) begin bad++; $display("FAIL first_req got=%b/%h exp=1/0000", imem_rd_o, imem_addr_o); end
    endtask

    task automatic test_sequential();
        imem_done_i = 1'b1; imem_rdata_i = 16'hC123;
        step();
        total++; if (instr_o !== 16'hC123)     begin bad++; $display("FAIL seq_instr0 got=%h exp=C123", instr_o); end
        total++; if (pc_plus2_o !== 16'h0002)  begin bad++; $display("FAIL seq_pc2_0 got=%h exp=0002", pc_plus2_o); end
        total++; if (valid_o !== 1'b1)         begin bad++; $display("FAIL seq_valid got=%b exp=1", valid_o); end
        total++; if (imem_addr_o !== 16'h0002) begin bad++; $display("FAIL seq_addr1 got=%h exp=0002", imem_addr_o); end
        imem_rdata_i = 16'h1111;
        step();
        total++; if (instr_o !== 16'h1111 || pc_plus2_o !== 16'h0004) begin bad++; $display("FAIL seq_instr1 got=%h/%h exp=1111/0004", instr_o, pc_plus2_o); end
        total++; if (imem_addr_o !== 16'h0004) begin bad++; $display("FAIL seq_addr2 got=%h exp=0004", imem_addr_o); end
    endtask

    task automatic test_mem_stall();
        imem_rdata_i = 16'h0000;
        repeat (6) step();
        total++; if (imem_addr_o !== 16'h0010) begin bad++; $display("FAIL ms_start_addr got=%h exp=0010", imem_addr_o); end
        imem_done_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0010) begin bad++; $display("FAIL ms_wait%0d got=%b/%h exp=1/0010", i, imem_rd_o, imem_addr_o); end
            total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL ms_bubble%0d got=%b exp=0", i, valid_o); end
        end
        imem_done_i = 1'b1; imem_rdata_i = 16'h2222;
        step();
        imem_done_i = 1'b0;
        total++; if (instr_o !== 16'h2222 || pc_plus2_o !== 16'h0012 || valid_o !== 1'b1) begin bad++; $display("FAIL ms_load got=%h/%h/%b exp=2222/0012/1", instr_o, pc_plus2_o, valid_o); end
    endtask

    task automatic test_hazard_stall();
        stall_i = 1'b1; imem_done_i = 1'b1; imem_rdata_i = 16'hA5A5;
        step();
        imem_done_i = 1'b0;
        total++; if (instr_o !== 16'h2222 || pc_plus2_o !== 16'h0012 || valid_o !== 1'b1) begin bad++; $display("FAIL hz_hold0 got=%h/%h/%b exp=2222/0012/1", instr_o, pc_plus2_o, valid_o); end
        total++; if (imem_rd_o !== 1'b0) begin bad++; $display("FAIL hz_rd0 got=%b exp=0", imem_rd_o); end
        for (int i = 1; i < 4; i++) begin
            step();
            total++; if (instr_o !== 16'h2222 || imem_rd_o !== 1'b0 || imem_addr_o !== 16'h0014) begin bad++; $display("FAIL hz_hold%0d got=%h/%b/%h exp=2222/0/0014", i, instr_o, imem_rd_o, imem_addr_o); end
        end
        stall_i = 1'b0;
        step();
        total++; if (instr_o !== 16'hA5A5 || pc_plus2_o !== 16'h0014 || valid_o !== 1'b1) begin bad++; $display("FAIL hz_release got=%h/%h/%b exp=A5A5/0014/1", instr_o, pc_plus2_o, valid_o); end
        total++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0014) begin bad++; $display("FAIL hz_next_addr got=%b/%h exp=1/0014", imem_rd_o, imem_addr_o); end
    endtask

    task automatic test_redirect();
        step();
        redirect_i = 1'b1; redirect_pc_i = 16'h0100;
        step();
        redirect_i = 1'b0;
        total++; if (valid_o !== 1'b0 || instr_o !== 16'h0800) begin bad++; $display("FAIL rd_flush got=%b/%h exp=0/0800", valid_o, instr_o); end
        total++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0014) begin bad++; $display("FAIL rd_drain0 got=%b/%h exp=1/0014", imem_rd_o, imem_addr_o); end
        step();
        total++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0014) begin bad++; $display("FAIL rd_drain1 got=%b/%h exp=1/0014", imem_rd_o, imem_addr_o); end
        imem_done_i = 1'b1; imem_rdata_i = 16'hDEAD;
        step();
        total++; if (valid_o !== 1'b0 || instr_o !== 16'h0800) begin bad++; $display("FAIL rd_dropped got=%b/%h exp=0/0800", valid_o, instr_o); end
        total++; if (imem_addr_o !== 16'h0100) begin bad++; $display("FAIL rd_target got=%h exp=0100", imem_addr_o); end
        imem_rdata_i = 16'h3333;
        step();
        total++; if (instr_o !== 16'h3333 || pc_plus2_o !== 16'h0102) begin bad++; $display("FAIL rd_fetch got=%h/%h exp=3333/0102", instr_o, pc_plus2_o); end
        redirect_i = 1'b1; redirect_pc_i = 16'h0100; imem_rdata_i = 16'hBEEF;
        step();
        redirect_i = 1'b0; imem_done_i = 1'b0;
        total++; if (valid_o !== 1'b0 || instr_o !== 16'h0800) begin bad++; $display("FAIL rd_same_flush got=%b/%h exp=0/0800", valid_o, instr_o); end
        total++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0100) begin bad++; $display("FAIL rd_same_addr got=%b/%h exp=1/0100", imem_rd_o, imem_addr_o); end
    endtask

    task automatic test_halt();
        halt_i = 1'b1;
        step();
        total++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0100 || valid_o !== 1'b0) begin bad++; $display("FAIL ht_finish got=%b/%h/%b exp=1/0100/0", imem_rd_o, imem_addr_o, valid_o); end
        halt_i = 1'b0; imem_done_i = 1'b1; imem_rdata_i = 16'h7777;
        step();
        imem_done_i = 1'b0;
        total++; if (imem_rd_o !== 1'b0 || valid_o !== 1'b0) begin bad++; $display("FAIL ht_enter got=%b/%b exp=0/0", imem_rd_o, valid_o); end
        for (int i = 0; i < 20; i++) begin
            step();
            total++; if (imem_rd_o !== 1'b0 || imem_addr_o !== 16'h0100) begin bad++; $display("FAIL ht_idle%0d got=%b/%h exp=0/0100", i, imem_rd_o, imem_addr_o); end
        end
        redirect_i = 1'b1; redirect_pc_i = 16'h0040;
        step();
        redirect_i = 1'b0;
        total++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0040) begin bad++; $display("FAIL ht_resume got=%b/%h exp=1/0040", imem_rd_o, imem_addr_o); end
        imem_done_i = 1'b1; imem_rdata_i = 16'h4444;
        step();
        imem_done_i = 1'b0;
        total++; if (instr_o !== 16'h4444 || pc_plus2_o !== 16'h0042) begin bad++; $display("FAIL ht_fetch got=%h/%h exp=4444/0042", instr_o, pc_plus2_o); end
    endtask

    task automatic test_wrap_err_reset();
        redirect_i = 1'b1; redirect_pc_i = 16'hFFFE; imem_done_i = 1'b1; imem_rdata_i = 16'h0000;
        step();
        redirect_i = 1'b0;
        total++; if (imem_addr_o !== 16'hFFFE) begin bad++; $display("FAIL wr_addr got=%h exp=FFFE", imem_addr_o); end
        imem_rdata_i = 16'h5555;
        step();
        total++; if (instr_o !== 16'h5555 || pc_plus2_o !== 16'h0000) begin bad++; $display("FAIL wr_pc2 got=%h/%h exp=5555/0000", instr_o, pc_plus2_o); end
        total++; if (imem_addr_o !== 16'h0000) begin bad++; $display("FAIL wr_wrap got=%h exp=0000", imem_addr_o); end
        imem_rdata_i = 16'h6666; imem_err_i = 1'b1;
        step();
        imem_done_i = 1'b0; imem_err_i = 1'b0;
        total++; if (instr_o !== 16'h6666 || err_o !== 1'b1 || valid_o !== 1'b1) begin bad++; $display("FAIL er_fwd got=%h/%b/%b exp=6666/1/1", instr_o, err_o, valid_o); end
        total++; if (imem_rd_o !== 1'b0) begin bad++; $display("FAIL er_halt got=%b exp=0", imem_rd_o); end
        step();
        total++; if (imem_rd_o !== 1'b0 || valid_o !== 1'b0) begin bad++; $display("FAIL er_halted got=%b/%b exp=0/0", imem_rd_o, valid_o); end
        redirect_i = 1'b1; redirect_pc_i = 16'h0041;
        step();
        total++; if (instr_o !== 16'h0800 || err_o !== 1'b1 || valid_o !== 1'b1 || imem_rd_o !== 1'b0) begin bad++; $display("FAIL er_misalign got=%h/%b/%b/%b exp=0800/1/1/0", instr_o, err_o, valid_o, imem_rd_o); end
        redirect_pc_i = 16'h0080;
        step();
        redirect_i = 1'b0;
        total++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0080) begin bad++; $display("FAIL er_restart got=%b/%h exp=1/0080", imem_rd_o, imem_addr_o); end
        step();
        total++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0080) begin bad++; $display("FAIL er_wait got=%b/%h exp=1/0080", imem_rd_o, imem_addr_o); end
        rst_n = 1'b0;
        #1;
        total++; if (imem_rd_o !== 1'b0 || imem_addr_o !== 16'h0000) begin bad++; $display("FAIL ar_req got=%b/%h exp=0/0000", imem_rd_o, imem_addr_o); end
        total++; if (instr_o !== 16'h0800 || pc_plus2_o !== 16'h0000 || valid_o !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL ar_ifid got=%h/%h/%b/%b exp=0800/0000/0/0", instr_o, pc_plus2_o, valid_o, err_o); end
        step();
        rst_n = 1'b1;
        step();
        total++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0000) begin bad++; $display("FAIL ar_restart got=%b/%h exp=1/0000", imem_rd_o, imem_addr_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_mem_stall();
        test_hazard_stall();
        test_redirect();
        test_halt();
        test_wrap_err_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
